// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Arbitrates the single write port of the 32x32 integer register file
// between the in-order ALU writeback stream and results from the
// long-latency load/store unit. LSU results are buffered in a 2-entry FIFO.
// A bounded-wait counter stops continuous ALU traffic from starving that
// FIFO. The block also keeps a scoreboard of destinations of outstanding
// loads, which decode uses to detect RAW hazards.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   alu_wb_valid/rd/data          ALU writeback offer
//   alu_wb_ready                  ALU writeback accepted this cycle
//   lsu_wb_valid/rd/data          LSU result offer
//   lsu_wb_ready                  LSU FIFO can accept a result
//   pend_set_valid/rd             load issued, mark destination busy
//   ra_i, rb_i / ra_busy, rb_busy decode source lookup into the scoreboard
//   RegWrite, rd_o, rd_value_o    register file write port
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  input  logic        pend_set_valid,
  input  logic [4:0]  pend_set_rd,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic        ra_busy,
  output logic        rb_busy,
  output logic        RegWrite,
  output logic [4:0]  rd_o,
  output logic [31:0] rd_value_o
);

  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lsu_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_FIFO
  } grant_e;

  // State
  lsu_entry_t  fifo_mem_q [2];
  lsu_entry_t  fifo_mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        run_q, run_d;

  // Combinational
  grant_e      grant;
  lsu_entry_t  head;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  assign fifo_empty = (count_q == 2'd0);
  assign head       = fifo_mem_q[rd_ptr_q];

  // run_q holds lsu_wb_ready low until the first edge after reset release.
  assign run_d        = 1'b1;
  assign lsu_wb_ready = run_q && (count_q != 2'd2);
  assign push         = lsu_wb_valid && lsu_wb_ready;
  assign pop          = (grant == GNT_FIFO);

  // Grant is suppressed while reset is held so the write port stays quiet
  // even though the upstream pipeline may still be presenting data.
  always_comb begin
    grant = GNT_NONE;
    if (rst) begin
      if (fifo_empty) begin
        if (alu_wb_valid) grant = GNT_ALU;
      end else if (alu_wb_valid && (starve_cnt_q < STARVE_MAX)) begin
        grant = GNT_ALU;
      end else begin
        grant = GNT_FIFO;
      end
    end
  end

  assign alu_wb_ready = !(pop && alu_wb_valid);

  // Write port
  always_comb begin
    RegWrite   = 1'b0;
    rd_o       = 5'd0;
    rd_value_o = 32'd0;
    case (grant)
      GNT_ALU: begin
        rd_o       = alu_wb_rd;
        rd_value_o = alu_wb_data;
      end
      GNT_FIFO: begin
        rd_o       = head.rd;
        rd_value_o = head.data;
      end
      default: ;
    endcase
    RegWrite = (grant != GNT_NONE) && (rd_o != 5'd0);
  end

  // FIFO bookkeeping. Ready is evaluated before the pop, so a full FIFO
  // never takes a push and simply drains by one on a pop.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{rd: lsu_wb_rd, data: lsu_wb_data};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The counter only measures how long a waiting head has lost to the ALU.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || fifo_empty) begin
      starve_cnt_d = 2'd0;
    end else if (grant == GNT_ALU && starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end
  end

  // Scoreboard: the set is applied after the clear so it wins on a collision.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.rd] = 1'b0;
    if (pend_set_valid && pend_set_rd != 5'd0) pend_d[pend_set_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign ra_busy = pend_q[ra_i];
  assign rb_busy = pend_q[rb_i];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed by the always_comb blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      starve_cnt_q <= 2'd0;
      pend_q       <= 32'd0;
      run_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      pend_q       <= pend_d;
      run_q        <= run_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read,
  // so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
